// File: rtl/selector41_arbiter.sv
// Round-robin arbiter sharing one 4-bit 4:1 selector among four requesters.
// Grant and select lines are registered. oZ is combinational from the select lines.
module selector41_arbiter #(
  parameter int MAX_HOLD = 4
) (
  input  logic       iClk,
  input  logic       iRst_n,
  input  logic [3:0] iReq,
  input  logic [3:0] iC0,
  input  logic [3:0] iC1,
  input  logic [3:0] iC2,
  input  logic [3:0] iC3,
  output logic [3:0] oGnt,
  output logic       oS1,
  output logic       oS0,
  output logic [3:0] oZ,
  output logic       oValid
);

  typedef enum logic {IDLE, GRANT} state_t;

  localparam logic [2:0] HoldMax = 3'(MAX_HOLD);

  state_t     state, stateNxt;
  logic [1:0] owner, ownerNxt;
  logic [1:0] ptr, ptrNxt;
  logic [2:0] cnt, cntNxt;
  logic [3:0] gntNxt;
  logic [1:0] ownerInc;
  logic [3:0] others;

  // First requester at or after start, wrapping modulo 4.
  function automatic logic [1:0] pick(input logic [3:0] req, input logic [1:0] start);
    logic [1:0] idx;
    logic [1:0] res;
    logic       found;
    res   = start;
    found = 1'b0;
    for (int i = 0; i < 4; i++) begin
      idx = start + 2'(i);
      if (!found && req[idx]) begin
        res   = idx;
        found = 1'b1;
      end
    end
    return res;
  endfunction

  always_comb begin
    stateNxt = state;
    ownerNxt = owner;
    ptrNxt   = ptr;
    cntNxt   = cnt;
    ownerInc = owner + 2'd1;
    others   = iReq & ~(4'b0001 << owner);
    case (state)
      IDLE: begin
        if (|iReq) begin
          stateNxt = GRANT;
          ownerNxt = pick(iReq, ptr);
          cntNxt   = 3'd1;
        end
      end
      GRANT: begin
        if (!iReq[owner]) begin
          ptrNxt = ownerInc;
          if (|iReq) begin
            ownerNxt = pick(iReq, ownerInc);
            cntNxt   = 3'd1;
          end else begin
            stateNxt = IDLE;
          end
        end else if (cnt == HoldMax && |others) begin
          // Pre-empt: searching from owner+1 cannot land on owner since another bit is set.
          ptrNxt   = ownerInc;
          ownerNxt = pick(iReq, ownerInc);
          cntNxt   = 3'd1;
        end else if (cnt < HoldMax) begin
          cntNxt = cnt + 3'd1;
        end
      end
    endcase
    gntNxt = (stateNxt == GRANT) ? (4'b0001 << ownerNxt) : 4'b0000;
  end

  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) begin
      state <= IDLE;
      owner <= 2'd0;
      ptr   <= 2'd0;
      cnt   <= 3'd0;
      oGnt  <= 4'b0000;
    end else begin
      state <= stateNxt;
      owner <= ownerNxt;
      ptr   <= ptrNxt;
      cnt   <= cntNxt;
      oGnt  <= gntNxt;
    end
  end

  assign oS1    = owner[1];
  assign oS0    = owner[0];
  assign oValid = |oGnt;

  always_comb begin
    case (owner)
      2'd0:    oZ = iC0;
      2'd1:    oZ = iC1;
      2'd2:    oZ = iC2;
      default: oZ = iC3;
    endcase
  end

endmodule
